// File: rtl/disp_slave_multi_if.sv
// disp_slave_multi_if: parallel write port from the bus slave
// plus display status and segment outputs.
interface disp_slave_multi_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGITS = 3
);
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic                    overrun;
  logic [7*NUM_DIGITS-1:0] seg_out;

  modport master (
    output wr_en, wr_data,
    input  busy, done, overflow, overrun, seg_out
  );

  modport slave (
    input  wr_en, wr_data,
    output busy, done, overflow, overrun, seg_out
  );
endinterface

// File: rtl/disp_slave_multi.sv
// disp_slave_multi: bus words -> binary -> BCD (double dabble) -> 7-seg.
// Option macro DISP_SLAVE_LEADING_ZERO_BLANK_EN blanks leading zeros.
module disp_slave_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 1,
  parameter int NUM_DIGITS = 3
) (
  input logic clk,
  input logic rst,
  disp_slave_multi_if.slave bus
);
  localparam int VW = DATA_WIDTH * WORDS;
  localparam int BW = 4 * NUM_DIGITS;
  localparam int GW = 7 * NUM_DIGITS;
  localparam int SW = (VW > 1) ? $clog2(VW) : 1;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] ZERO = 7'b1000000;
`ifdef DISP_SLAVE_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = ZERO;
`endif

  typedef enum logic [1:0] {
    IDLE, COLLECT, CONVERT, UPDATE
  } state_t;

  function automatic logic [GW-1:0] seg_rst();
    logic [GW-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      s[7*k +: 7] = (k == 0) ? ZERO : LZ;
    return s;
  endfunction

  localparam logic [GW-1:0] SEG_RST = seg_rst();

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = DASH;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   step_q;
  logic [VW-1:0]   asm_q, asm_next;
  logic [VW-1:0]   bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d, adj;
  logic            carry;
  logic            ovf_q;
  logic            overflow_q;
  logic            overrun_q;
  logic            done_q;
  logic [GW-1:0]   seg_q, seg_d;
  logic [3:0]      dig;
  logic            wr_en;
  logic            busy;
  logic            last_word;
`ifdef DISP_SLAVE_LEADING_ZERO_BLANK_EN
  logic            lead;
`endif

  assign wr_en     = bus.wr_en;
  assign busy      = (state_q == CONVERT) || (state_q == UPDATE);
  assign last_word = (cnt_q == CW'(WORDS - 1));
  assign asm_next  = (asm_q << DATA_WIDTH) | VW'(bus.wr_data);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (wr_en) state_d = (WORDS == 1) ? CONVERT : COLLECT;
      COLLECT:
        if (wr_en && last_word) state_d = CONVERT;
      CONVERT:
        if (step_q == SW'(VW - 1)) state_d = UPDATE;
      UPDATE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // One double-dabble step; carry is the bit lost off the top digit.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    {carry, bcd_d, bin_d} = {adj, bin_q, 1'b0};
  end

  always_comb begin
    seg_d = '0;
    dig   = '0;
`ifdef DISP_SLAVE_LEADING_ZERO_BLANK_EN
    lead  = 1'b1;
`endif
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      dig = bcd_q[4*k +: 4];
      seg_d[7*k +: 7] = ovf_q ? DASH : seg7(dig);
`ifdef DISP_SLAVE_LEADING_ZERO_BLANK_EN
      if (!ovf_q && lead && dig == 4'd0 && k != 0)
        seg_d[7*k +: 7] = LZ;
      if (dig != 4'd0) lead = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      asm_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= SEG_RST;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (wr_en && busy) overrun_q <= 1'b1;
      unique case (state_q)
        IDLE:
          if (wr_en) begin
            if (WORDS == 1) begin
              bin_q  <= VW'(bus.wr_data);
              bcd_q  <= '0;
              ovf_q  <= 1'b0;
              step_q <= '0;
            end else begin
              asm_q <= VW'(bus.wr_data);
              cnt_q <= CW'(1);
            end
          end
        COLLECT:
          if (wr_en) begin
            if (last_word) begin
              bin_q  <= asm_next;
              bcd_q  <= '0;
              ovf_q  <= 1'b0;
              step_q <= '0;
              cnt_q  <= '0;
            end else begin
              asm_q <= asm_next;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        CONVERT: begin
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          ovf_q  <= ovf_q | carry;
          step_q <= step_q + SW'(1);
        end
        UPDATE: begin
          seg_q      <= seg_d;
          overflow_q <= ovf_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.overrun  = overrun_q;
  assign bus.seg_out  = seg_q;
endmodule

// File: tb/tb_disp_slave_multi.sv
// tb_disp_slave_multi: directed checks on three configurations
// (defaults, 2 digits, 2 words x 4 digits).
module tb_disp_slave_multi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_slave_multi_if #(.DATA_WIDTH(8), .NUM_DIGITS(3)) if0 ();
  disp_slave_multi_if #(.DATA_WIDTH(8), .NUM_DIGITS(2)) if1 ();
  disp_slave_multi_if #(.DATA_WIDTH(8), .NUM_DIGITS(4)) if2 ();

  disp_slave_multi #(
    .DATA_WIDTH(8), .WORDS(1), .NUM_DIGITS(3)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));
  disp_slave_multi #(
    .DATA_WIDTH(8), .WORDS(1), .NUM_DIGITS(2)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));
  disp_slave_multi #(
    .DATA_WIDTH(8), .WORDS(2), .NUM_DIGITS(4)
  ) u2 (.clk(clk), .rst(rst), .bus(if2));

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] DSH = 7'b0111111;
`ifdef DISP_SLAVE_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = S0;
`endif

  task automatic wr(input int d, input logic [7:0] v);
    case (d)
      0: begin if0.wr_en = 1'b1; if0.wr_data = v; end
      1: begin if1.wr_en = 1'b1; if1.wr_data = v; end
      default: begin if2.wr_en = 1'b1; if2.wr_data = v; end
    endcase
    @(posedge clk); #1;
    if0.wr_en = 1'b0;
    if1.wr_en = 1'b0;
    if2.wr_en = 1'b0;
  endtask

  function automatic logic done_of(input int d);
    case (d)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  // Cycles from the write edge until done; 0 means it never came.
  task automatic wait_done(input int d, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done_of(d)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (if0.seg_out !== {LZ, LZ, S0}) begin
      bad++;
      $display("FAIL reset_seg0 got=%b exp=%b",
               if0.seg_out, {LZ, LZ, S0});
    end
    total++;
    if ({if0.busy, if0.done, if0.overflow, if0.overrun} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags0 got=%b exp=0000",
               {if0.busy, if0.done, if0.overflow, if0.overrun});
    end
    total++;
    if (if1.seg_out !== {LZ, S0}) begin
      bad++;
      $display("FAIL reset_seg1 got=%b exp=%b", if1.seg_out, {LZ, S0});
    end
    total++;
    if (if2.seg_out !== {LZ, LZ, LZ, S0}) begin
      bad++;
      $display("FAIL reset_seg2 got=%b exp=%b",
               if2.seg_out, {LZ, LZ, LZ, S0});
    end
  endtask

  task automatic test_convert_123();
    int n;
    wr(0, 8'd123);
    total++;
    if (if0.busy !== 1'b1) begin
      bad++;
      $display("FAIL c123_busy got=%b exp=1", if0.busy);
    end
    wait_done(0, n);
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL c123_latency got=%0d exp=9", n);
    end
    total++;
    if (if0.seg_out !== {S1, S2, S3}) begin
      bad++;
      $display("FAIL c123_seg got=%b exp=%b", if0.seg_out, {S1, S2, S3});
    end
    total++;
    if (if0.overflow !== 1'b0) begin
      bad++;
      $display("FAIL c123_ovf got=%b exp=0", if0.overflow);
    end
    @(posedge clk); #1;
    total++;
    if ({if0.done, if0.busy} !== 2'b00) begin
      bad++;
      $display("FAIL c123_after got=%b exp=00", {if0.done, if0.busy});
    end
    total++;
    if (if0.seg_out !== {S1, S2, S3}) begin
      bad++;
      $display("FAIL c123_hold got=%b exp=%b", if0.seg_out, {S1, S2, S3});
    end
  endtask

  task automatic test_zero_255();
    int n;
    wr(0, 8'd0);
    wait_done(0, n);
    total++;
    if (n != 9 || if0.seg_out !== {LZ, LZ, S0}) begin
      bad++;
      $display("FAIL zero_seg got=%b n=%0d exp=%b n=9",
               if0.seg_out, n, {LZ, LZ, S0});
    end
    wr(0, 8'd255);
    wait_done(0, n);
    total++;
    if (n != 9 || if0.seg_out !== {S2, S5, S5}) begin
      bad++;
      $display("FAIL c255_seg got=%b n=%0d exp=%b n=9",
               if0.seg_out, n, {S2, S5, S5});
    end
  endtask

  task automatic test_overflow();
    int n;
    wr(1, 8'd123);
    wait_done(1, n);
    total++;
    if (n != 9 || if1.seg_out !== {DSH, DSH}) begin
      bad++;
      $display("FAIL ovf_seg got=%b n=%0d exp=%b n=9",
               if1.seg_out, n, {DSH, DSH});
    end
    total++;
    if (if1.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag got=%b exp=1", if1.overflow);
    end
    wr(1, 8'd99);
    wait_done(1, n);
    total++;
    if (n != 9 || if1.seg_out !== {S9, S9}) begin
      bad++;
      $display("FAIL c99_seg got=%b n=%0d exp=%b n=9",
               if1.seg_out, n, {S9, S9});
    end
    total++;
    if (if1.overflow !== 1'b0) begin
      bad++;
      $display("FAIL c99_ovf got=%b exp=0", if1.overflow);
    end
  endtask

  task automatic test_multi_word();
    int n;
    logic seen_busy;
    seen_busy = 1'b0;
    wr(2, 8'h04);
    for (int i = 0; i < 4; i++) begin
      if (if2.busy !== 1'b0) seen_busy = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen_busy) begin
      bad++;
      $display("FAIL mw_busy_gap got=1 exp=0");
    end
    wr(2, 8'hD2);
    total++;
    if (if2.busy !== 1'b1) begin
      bad++;
      $display("FAIL mw_busy got=%b exp=1", if2.busy);
    end
    wait_done(2, n);
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL mw_latency got=%0d exp=17", n);
    end
    total++;
    if (if2.seg_out !== {S1, S2, S3, S4}) begin
      bad++;
      $display("FAIL mw_seg got=%b exp=%b",
               if2.seg_out, {S1, S2, S3, S4});
    end
    total++;
    if (if2.overflow !== 1'b0) begin
      bad++;
      $display("FAIL mw_ovf got=%b exp=0", if2.overflow);
    end
  endtask

  task automatic test_overrun();
    int n;
    logic seen_done;
    seen_done = 1'b0;
    wr(0, 8'd7);
    wr(0, 8'd9);
    total++;
    if (if0.overrun !== 1'b1) begin
      bad++;
      $display("FAIL orun_set got=%b exp=1", if0.overrun);
    end
    wait_done(0, n);
    total++;
    if (n == 0 || if0.seg_out !== {LZ, LZ, S7}) begin
      bad++;
      $display("FAIL orun_seg got=%b n=%0d exp=%b",
               if0.seg_out, n, {LZ, LZ, S7});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (if0.overrun !== 1'b1) begin
      bad++;
      $display("FAIL orun_sticky got=%b exp=1", if0.overrun);
    end
    wr(0, 8'd200);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (if0.seg_out !== {LZ, LZ, S0}) begin
      bad++;
      $display("FAIL midrst_seg got=%b exp=%b",
               if0.seg_out, {LZ, LZ, S0});
    end
    total++;
    if ({if0.busy, if0.overflow, if0.overrun} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_flags got=%b exp=000",
               {if0.busy, if0.overflow, if0.overrun});
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if0.done) seen_done = 1'b1;
    end
    total++;
    if (seen_done || if0.seg_out !== {LZ, LZ, S0}) begin
      bad++;
      $display("FAIL midrst_quiet got=%b/%b exp=0/%b",
               seen_done, if0.seg_out, {LZ, LZ, S0});
    end
  endtask

  task automatic test_blank();
    int n;
    wr(0, 8'd5);
    wait_done(0, n);
    total++;
    if (n != 9 || if0.seg_out !== {LZ, LZ, S5}) begin
      bad++;
      $display("FAIL c5_seg got=%b n=%0d exp=%b n=9",
               if0.seg_out, n, {LZ, LZ, S5});
    end
  endtask

  initial begin
    rst = 1'b1;
    if0.wr_en = 1'b0; if0.wr_data = '0;
    if1.wr_en = 1'b0; if1.wr_data = '0;
    if2.wr_en = 1'b0; if2.wr_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_convert_123();
    test_zero_255();
    test_overflow();
    test_multi_word();
    test_overrun();
    test_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/disp_slave_multi.md
Name: disp_slave_multi

Overview:
- Parametrised successor to the single-byte display slave.
- Sits behind the serial-bus slave's parallel write port (write strobe plus data word).
- Assembles one or more bus words into a wide unsigned value and converts it to BCD with a sequential shift-add-3 engine.
- Drives NUM_DIGITS active-low seven-segment digits, flags overflow, and reports busy and overrun back toward the bus side.

Parameters:
- DATA_WIDTH, 8, width of one bus data word.
- WORDS, 1, bus words per display frame; VALUE_WIDTH = DATA_WIDTH*WORDS.
- NUM_DIGITS, 3, decimal digits driven (>=1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe from the slave (write_en_internal).
- wr_data  in  DATA_WIDTH  word written by the bus master (data_out_parellel).
- busy  out  1  high while a conversion is in progress; drives the slave-busy path.
- done  out  1  one-cycle pulse when seg_out updates.
- overflow  out  1  last frame value >= 10^NUM_DIGITS.
- overrun  out  1  sticky: a write arrived while busy.
- seg_out  out  7*NUM_DIGITS  digit k occupies [7k+6:7k]; digit 0 is least significant.

Behaviour:
- Segment encoding: bit order gfedcba, active-low. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Dash = 0111111.
- Reset, which overrides everything including mid-conversion: state IDLE, word counter 0, busy=0, done=0, overflow=0, overrun=0, every digit shows 0 (1000000).
- State IDLE:
  - wr_en=1 and WORDS=1: load wr_data into the shift register, clear the BCD register, go to CONVERT.
  - wr_en=1 and WORDS>1: store the word as most significant, word counter=1, go to COLLECT.
- State COLLECT:
  - Each wr_en shifts the assembly register left by DATA_WIDTH and inserts wr_data; the first word received is the most significant.
  - When the counter reaches WORDS-1 and wr_en=1, load the full value and go to CONVERT; the counter returns to 0.
  - No timeout; a partial frame waits indefinitely until reset.
- State CONVERT:
  - Exactly VALUE_WIDTH cycles, one double-dabble step per cycle: add 3 to every BCD nibble >=5, then shift {bcd, bin} left by one.
  - Any 1 shifted out of the top BCD nibble sets an internal overflow flag.
  - After the last step go to UPDATE.
- State UPDATE (1 cycle):
  - Register seg_out from the BCD digits, or all dashes if the overflow flag is set.
  - Copy the internal flag to overflow, pulse done=1, return to IDLE.
- Timing: if wr_en for the final word is sampled at edge E0, seg_out and done change at edge E0+VALUE_WIDTH+1. busy is high from the cycle after E0 through the UPDATE cycle inclusive.
- busy is low in IDLE and COLLECT.
- Any wr_en sampled while busy=1 is ignored: the data is dropped and overrun is set to 1. overrun clears only on rst.
- seg_out and overflow hold their previous frame's values until the next UPDATE.
- A value exactly 10^NUM_DIGITS-1 is not an overflow. A value of 0 displays all zeros.

Optional Feature:
- Macro: DISP_SLAVE_LEADING_ZERO_BLANK_EN.
- Defined: in UPDATE, every zero digit above the most significant non-zero digit shows blank (1111111). Digit 0 always shows its value, so a value of 0 shows only digit 0 as 0. The reset value of digits 1..NUM_DIGITS-1 is blank. Dashes on overflow are unaffected.
- Undefined: leading zeros are displayed as 0.

Test Plan:
- Defaults, write 8'd123 -> 9 cycles later done=1; digits 2/1/0 = 1111001/0100100/0110000; overflow=0.
- Defaults, write 8'd0 then 8'd255 (second write after done) -> 1000000 on all digits, then 0100100/0010010/0010010.
- NUM_DIGITS=2, write 8'd123 -> both digits 0111111, overflow=1; then 8'd99 -> 0010000/0010000, overflow=0.
- WORDS=2, NUM_DIGITS=4, write 8'h04 then 8'hD2 (=1234) -> busy stays low between words; done 17 cycles after the second write; digits 1,2,3,4.
- Defaults, write 8'd7, then wr_en with 8'd9 while busy -> overrun=1; display shows 7; rst mid-conversion of a later write -> all outputs at reset values, overrun=0.
- With DISP_SLAVE_LEADING_ZERO_BLANK_EN, write 8'd5 -> digits 2/1 = 1111111, digit 0 = 0010010.
